// File: rtl/coinc_trigger_n.sv
// Majority coincidence trigger over stretched active-low coax hits, with dead time, prescale, passthrough, histograms and a rolling trigger.
// Latency: input sampled low to coax_out high in 3 cycles; no backpressure, every input is sampled each cycle.
module coinc_trigger_n #(
    parameter int NCH     = 16,
    parameter int CW      = 8,
    parameter int HW      = 32,
    parameter int OUT_LEN = 16,
    localparam int MW     = $clog2(NCH + 1)
) (
    input  logic             clk_adc,
    input  logic             reset,
    input  logic [NCH-1:0]   coax_in,
    output logic [NCH-1:0]   coax_out,
    input  logic [CW-1:0]    coincidence_time,
    input  logic [CW-1:0]    dead_time,
    input  logic [NCH-1:0]   trig_mask,
    input  logic [MW-1:0]    majority,
    input  logic [31:0]      randnum,
    input  logic [31:0]      prescale,
    input  logic             dorolling,
    input  logic [4:0]       rolling_log2,
    input  logic             resethist,
    input  logic [7:0]       hist_sel,
    output logic [HW-1:0]    hist_out,
    output logic             trig_out,
    output logic [31:0]      accept_count,
    output logic             ext_trig_out,
    output logic             dead
);

    localparam int            IW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] OUT_LEN_C = CW'(OUT_LEN);
    localparam logic [HW-1:0] HIST_MAX  = '1;
    localparam logic [8:0]    NCH_L     = 9'(NCH);

    typedef enum logic {S_IDLE, S_DEAD} state_t;

    logic [NCH-1:0] r_inreg;
    logic [NCH-1:0] r_inreg_d;
    logic [CW-1:0]  r_tin  [NCH];
    logic [CW-1:0]  r_tout [NCH];
    logic [NCH-1:0] r_coax_out;
    logic [HW-1:0]  r_hist [NCH];
    logic [HW-1:0]  r_hist_out;
    logic [31:0]    r_accept;
    logic [31:0]    r_prescale;
    logic           r_pass_prescale;
    logic           r_trig;
    state_t         r_state;
    logic [CW-1:0]  r_deadcnt;
    logic [31:0]    r_auto;
    logic [2:0]     r_ext_cnt;

    logic [NCH-1:0] w_active;
    logic [NCH-1:0] w_grp;
    logic [MW-1:0]  w_cnt;
    logic           w_cond;
    state_t         w_state_nxt;
    logic [CW-1:0]  w_deadcnt_nxt;
    logic           w_decide;
    logic           w_accept;
    logic           w_roll_fire;
    logic [IW-1:0]  w_sel_idx;
    logic           w_sel_ok;

    always_comb begin
        w_active = '0;
        for (int j = 0; j < NCH; j++) begin
            w_active[j] = (r_tin[j] != '0);
        end
    end

    assign w_grp = w_active & trig_mask;

    always_comb begin
        w_cnt = '0;
        for (int j = 0; j < NCH; j++) begin
            w_cnt = w_cnt + MW'(w_grp[j]);
        end
    end

    assign w_cond = (majority != '0) && (w_cnt >= majority);

    // The decision is taken only in IDLE; DEAD ignores cond entirely.
    always_comb begin
        w_state_nxt   = r_state;
        w_deadcnt_nxt = r_deadcnt;
        w_decide      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cond) begin
                    w_state_nxt   = S_DEAD;
                    w_deadcnt_nxt = dead_time;
                    w_decide      = 1'b1;
                end
            end
            S_DEAD: begin
                if (r_deadcnt <= CW'(1)) begin
                    w_state_nxt   = S_IDLE;
                    w_deadcnt_nxt = '0;
                end else begin
                    w_deadcnt_nxt = r_deadcnt - CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = w_decide && r_pass_prescale;

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_deadcnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_deadcnt <= w_deadcnt_nxt;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            r_inreg         <= '0;
            r_inreg_d       <= '0;
            r_prescale      <= '0;
            r_pass_prescale <= 1'b0;
            r_trig          <= 1'b0;
            r_coax_out      <= '0;
            for (int j = 0; j < NCH; j++) begin
                r_tin[j]  <= '0;
                r_tout[j] <= '0;
            end
        end else begin
            r_inreg         <= ~coax_in;
            r_inreg_d       <= r_inreg;
            r_prescale      <= prescale;
            r_pass_prescale <= (randnum <= r_prescale);
            r_trig          <= w_accept;
            for (int j = 0; j < NCH; j++) begin
                if (r_inreg[j]) begin
                    r_tin[j] <= coincidence_time;
                end else if (r_tin[j] != '0) begin
                    r_tin[j] <= r_tin[j] - CW'(1);
                end
                // Unmasked channels pass straight through regardless of FSM state.
                if ((w_accept && trig_mask[j]) || (!trig_mask[j] && w_active[j])) begin
                    r_tout[j] <= OUT_LEN_C;
                end else if (r_tout[j] != '0) begin
                    r_tout[j] <= r_tout[j] - CW'(1);
                end
                r_coax_out[j] <= (r_tout[j] != '0);
            end
        end
    end

    assign w_sel_idx = hist_sel[IW-1:0];
    assign w_sel_ok  = ({1'b0, hist_sel} < NCH_L);

    always_ff @(posedge clk_adc) begin
        if (reset || resethist) begin
            r_accept <= '0;
            for (int j = 0; j < NCH; j++) begin
                r_hist[j] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_accept <= r_accept + 32'd1;
            end
            for (int j = 0; j < NCH; j++) begin
                if (r_inreg[j] && !r_inreg_d[j] && (r_hist[j] != HIST_MAX)) begin
                    r_hist[j] <= r_hist[j] + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            r_hist_out <= '0;
        end else begin
            r_hist_out <= w_sel_ok ? r_hist[w_sel_idx] : '0;
        end
    end

    // Counter wraps on reaching 2^rolling_log2, so one period is 2^rolling_log2 + 1 cycles.
    assign w_roll_fire = r_auto[rolling_log2];

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            r_auto    <= '0;
            r_ext_cnt <= '0;
        end else begin
            r_auto <= w_roll_fire ? '0 : r_auto + 32'd1;
            if (w_roll_fire && dorolling) begin
                r_ext_cnt <= 3'd4;
            end else if (r_ext_cnt != '0) begin
                r_ext_cnt <= r_ext_cnt - 3'd1;
            end
        end
    end

    assign coax_out     = r_coax_out;
    assign hist_out     = r_hist_out;
    assign trig_out     = r_trig;
    assign accept_count = r_accept;
    assign ext_trig_out = (r_ext_cnt != '0);
    assign dead         = (r_state == S_DEAD);

endmodule

// File: tb/tb_coinc_trigger_n.sv
// Directed bench for coinc_trigger_n: coincidence, dead time, prescale, passthrough, rolling trigger, histograms, reset.
// Histograms use a 4-bit width so saturation is reachable with a handful of hits.
module tb_coinc_trigger_n;

    localparam int NCH = 16;
    localparam int CW  = 8;
    localparam int HW  = 4;
    localparam int MW  = 5;

    logic            clk_adc = 1'b0;
    logic            reset;
    logic [NCH-1:0]  coax_in;
    logic [NCH-1:0]  coax_out;
    logic [CW-1:0]   coincidence_time;
    logic [CW-1:0]   dead_time;
    logic [NCH-1:0]  trig_mask;
    logic [MW-1:0]   majority;
    logic [31:0]     randnum;
    logic [31:0]     prescale;
    logic            dorolling;
    logic [4:0]      rolling_log2;
    logic            resethist;
    logic [7:0]      hist_sel;
    logic [HW-1:0]   hist_out;
    logic            trig_out;
    logic [31:0]     accept_count;
    logic            ext_trig_out;
    logic            dead;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_adc = ~clk_adc;

    coinc_trigger_n #(.NCH(NCH), .CW(CW), .HW(HW), .OUT_LEN(16)) dut (
        .clk_adc          (clk_adc),
        .reset            (reset),
        .coax_in          (coax_in),
        .coax_out         (coax_out),
        .coincidence_time (coincidence_time),
        .dead_time        (dead_time),
        .trig_mask        (trig_mask),
        .majority         (majority),
        .randnum          (randnum),
        .prescale         (prescale),
        .dorolling        (dorolling),
        .rolling_log2     (rolling_log2),
        .resethist        (resethist),
        .hist_sel         (hist_sel),
        .hist_out         (hist_out),
        .trig_out         (trig_out),
        .accept_count     (accept_count),
        .ext_trig_out     (ext_trig_out),
        .dead             (dead)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_adc);
        #1;
    endtask

    task automatic hit(input logic [NCH-1:0] chans);
        coax_in = ~chans;
        step();
        coax_in = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, t, gap, last, mingap, ntrig, run, nruns, n7, ndead;
        logic grp_seen, trig_seen, ext_seen;

        reset = 1'b1; coax_in = '0; coincidence_time = 8'd4; dead_time = 8'd10;
        trig_mask = 16'h0003; majority = 5'd2; randnum = $urandom; prescale = 32'hFFFF_FFFF;
        dorolling = 1'b1; rolling_log2 = 5'd0; resethist = 1'b0; hist_sel = 8'd0;
        repeat (3) step();
        check("rst_coax_out", 64'(coax_out), 64'd0);
        check("rst_trig_out", 64'(trig_out), 64'd0);
        check("rst_ext_trig", 64'(ext_trig_out), 64'd0);
        check("rst_dead", 64'(dead), 64'd0);
        check("rst_hist_out", 64'(hist_out), 64'd0);
        check("rst_accept", 64'(accept_count), 64'd0);

        reset = 1'b0; coax_in = '1; dorolling = 1'b0;
        repeat (4) step();

        // Two hits two cycles apart on the masked pair.
        hit(16'h0001); step(); hit(16'h0002);
        step();
        step();
        check("trig_at_e2", 64'(trig_out), 64'd1);
        check("grp_out_e2", 64'(coax_out[1:0]), 64'd0);
        check("accept_1", 64'(accept_count), 64'd1);
        check("dead_e2", 64'(dead), 64'd1);
        step();
        check("grp_out_e3", 64'(coax_out[1:0]), 64'd3);
        check("trig_one_cycle", 64'(trig_out), 64'd0);
        n = 0;
        while (coax_out[0] && n < 100) begin n++; step(); end
        check("grp_pulse_len", 64'(n), 64'd16);
        hist_sel = 8'd0; step();
        check("hist0_after_a", 64'(hist_out), 64'd1);

        // Hits five cycles apart never overlap.
        resethist = 1'b1; step(); resethist = 1'b0;
        check("accept_cleared", 64'(accept_count), 64'd0);
        hit(16'h0001); repeat (4) step(); hit(16'h0002);
        grp_seen = 1'b0; trig_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (coax_out[1:0] != 2'b00) grp_seen = 1'b1;
            if (trig_out) trig_seen = 1'b1;
        end
        check("far_no_group_out", 64'(grp_seen), 64'd0);
        check("far_no_trig", 64'(trig_seen), 64'd0);
        check("far_accept", 64'(accept_count), 64'd0);
        hist_sel = 8'd0; step();
        check("far_hist0", 64'(hist_out), 64'd1);
        hist_sel = 8'd1; step();
        check("far_hist1", 64'(hist_out), 64'd1);

        // Coincidence every 3 cycles: triggers at edges 2, 13, 24, 35.
        last = -1; mingap = 1000; ntrig = 0; run = 0; nruns = 0;
        for (int c = 0; c < 50; c++) begin
            coax_in[1:0] = ((c % 3 == 0) && (c <= 33)) ? 2'b00 : 2'b11;
            step();
            if (trig_out) begin
                ntrig++;
                if (last >= 0 && (c - last) < mingap) mingap = c - last;
                last = c;
            end
            if (dead) run++;
            else if (run != 0) begin
                check("dead_run_len", 64'(run), 64'd10);
                nruns++;
                run = 0;
            end
        end
        coax_in = '1;
        check("rep_trig_count", 64'(ntrig), 64'd4);
        check("rep_min_gap", 64'(mingap), 64'd11);
        check("rep_dead_runs", 64'(nruns), 64'd4);
        check("rep_accept", 64'(accept_count), 64'd4);

        // Prescale rejects everything; channel 7 is outside the group.
        prescale = 32'd0; randnum = 32'd5; coincidence_time = 8'd1;
        repeat (3) step();
        hit(16'h0083);
        n7 = 0; ndead = 0; grp_seen = 1'b0; trig_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (coax_out[7]) n7++;
            if (dead) ndead++;
            if (coax_out[1:0] != 2'b00) grp_seen = 1'b1;
            if (trig_out) trig_seen = 1'b1;
        end
        check("ps_no_group_out", 64'(grp_seen), 64'd0);
        check("ps_no_trig", 64'(trig_seen), 64'd0);
        check("ps_dead_len", 64'(ndead), 64'd10);
        check("ps_ch7_len", 64'(n7), 64'd16);
        check("ps_accept_held", 64'(accept_count), 64'd4);

        // Rolling trigger with period 17.
        rolling_log2 = 5'd4; dorolling = 1'b1;
        t = 0;
        while (!ext_trig_out && t < 40) begin step(); t++; end
        check("roll_found", 64'(t < 40), 64'd1);
        n = 0;
        while (ext_trig_out && n < 40) begin n++; step(); end
        check("roll_high_len", 64'(n), 64'd4);
        gap = n;
        while (!ext_trig_out && gap < 60) begin gap++; step(); end
        check("roll_period", 64'(gap), 64'd17);
        dorolling = 1'b0;
        repeat (5) step();
        ext_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ext_trig_out) ext_seen = 1'b1;
        end
        check("roll_disabled", 64'(ext_seen), 64'd0);

        // Histogram saturation, clear priority, out-of-range select.
        resethist = 1'b1; step(); resethist = 1'b0;
        hist_sel = 8'd3;
        for (int i = 0; i < 14; i++) begin hit(16'h0008); step(); end
        step();
        check("hist3_count14", 64'(hist_out), 64'd14);
        for (int i = 0; i < 2; i++) begin hit(16'h0008); step(); end
        step();
        check("hist3_saturate", 64'(hist_out), 64'd15);
        coax_in[3] = 1'b0; resethist = 1'b1; step();
        coax_in = '1; step();
        resethist = 1'b0; step();
        check("hist3_clear_prio", 64'(hist_out), 64'd0);
        hit(16'h0010); step();
        hist_sel = 8'd4; step();
        check("hist4_one", 64'(hist_out), 64'd1);
        hist_sel = 8'd20; step();
        check("hist_sel_range", 64'(hist_out), 64'd0);

        // Reset in the middle of a group pulse and DEAD.
        prescale = 32'hFFFF_FFFF; coincidence_time = 8'd4;
        repeat (3) step();
        hit(16'h0003);
        repeat (3) step();
        check("pre_rst_pulse", 64'(coax_out[1:0]), 64'd3);
        check("pre_rst_dead", 64'(dead), 64'd1);
        reset = 1'b1; step();
        check("mid_rst_coax", 64'(coax_out), 64'd0);
        check("mid_rst_dead", 64'(dead), 64'd0);
        check("mid_rst_accept", 64'(accept_count), 64'd0);
        reset = 1'b0; step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coinc_trigger_n.md
COINC_TRIGGER_N -- requirements
Module: coinc_trigger_n

Interface
REQ-001 Parameter NCH, default 16, number of coax channels (2..64).
REQ-002 Parameter CW, default 8, width of coincidence-stretch and dead-time counters.
REQ-003 Parameter HW, default 32, width of each per-channel histogram counter.
REQ-004 Parameter OUT_LEN, default 16, output pulse length in clk_adc cycles (1..2^CW-1).
REQ-005 Derived MW = $clog2(NCH+1).
REQ-006 clk_adc  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 coax_in  input  NCH  trigger inputs, active-low (unconnected reads as inactive).
REQ-009 coax_out  output  NCH  registered output pulses, active-high.
REQ-010 coincidence_time  input  CW  stretch length of each input hit, in cycles.
REQ-011 dead_time  input  CW  dead cycles after each group trigger decision.
REQ-012 trig_mask  input  NCH  1 = channel belongs to the coincidence group.
REQ-013 majority  input  MW  minimum number of simultaneously active group channels.
REQ-014 randnum  input  32  random number for prescaling.
REQ-015 prescale  input  32  accept threshold.
REQ-016 dorolling  input  1  enables the periodic rolling trigger.
REQ-017 rolling_log2  input  5  rolling period select.
REQ-018 resethist  input  1  clears histograms and accept counter.
REQ-019 hist_sel  input  8  channel whose histogram is presented on hist_out.
REQ-020 hist_out  output  HW  registered histogram value.
REQ-021 trig_out  output  1  one-cycle pulse per accepted group trigger.
REQ-022 accept_count  output  32  number of accepted group triggers.
REQ-023 ext_trig_out  output  1  rolling trigger pulse.
REQ-024 dead  output  1  high while the FSM is in DEAD.

Function
REQ-025 Stage 1: inreg[j] <= ~coax_in[j].
REQ-026 Stretch: when inreg[j]=1, Tin[j] <= coincidence_time; otherwise Tin[j] decrements, saturating at 0.
REQ-027 active[j] = (Tin[j] != 0); with coincidence_time = 0, a channel is never active.
REQ-028 cnt = popcount(active & trig_mask); cond = (majority != 0) && (cnt >= majority).
REQ-029 pass_prescale <= (randnum <= prescale_r), where prescale_r <= prescale; prescale = 32'hFFFFFFFF always passes.
REQ-030 FSM states: IDLE, DEAD.
REQ-031 In IDLE with cond=1, the FSM moves to DEAD and loads deadcnt <= dead_time.
REQ-032 When that IDLE decision occurs and pass_prescale=1: Tout[j] <= OUT_LEN for every j with trig_mask[j]=1; trig_out pulses for 1 cycle; accept_count increments (wraps at 2^32).
REQ-033 When that IDLE decision occurs and pass_prescale=0: no output and no count, but DEAD is still entered.
REQ-034 In DEAD: if deadcnt <= 1, go to IDLE and set deadcnt <= 0; otherwise decrement. Dead interval is max(dead_time,1) cycles; cond is ignored in DEAD.
REQ-035 Passthrough: for trig_mask[j]=0 and active[j]=1, Tout[j] <= OUT_LEN every cycle, independent of FSM state.
REQ-036 Tout[j] decrements to 0 when not reloaded; a reload while nonzero restarts at OUT_LEN.
REQ-037 coax_out[j] <= (Tout[j] != 0).
REQ-038 Latency: coax_in sampled low at edge E0 gives coax_out high after edge E3 (group, IDLE, prescale passing, majority met at E1) and stays high exactly OUT_LEN cycles.
REQ-039 Histogram: hist[j] increments on each rising edge of inreg[j] (0->1), saturating at 2^HW-1.
REQ-040 resethist clears all hist[j] and accept_count; it has priority over increments and does not affect the FSM or the Tin/Tout counters.
REQ-041 hist_out <= hist[hist_sel] when hist_sel < NCH; otherwise hist_out <= 0.
REQ-042 Rolling: a 32-bit autocounter increments each cycle.
REQ-043 When autocounter[rolling_log2] = 1, autocounter <= 0 and, if dorolling=1, ext_trig_out is held high for 4 cycles; the period is 2^rolling_log2 + 1 cycles.
REQ-044 Control inputs (trig_mask, majority, dead_time, coincidence_time) take effect on the next evaluation; a change mid-DEAD does not alter the loaded deadcnt.

Reset
REQ-045 reset=1 clears inreg, Tin, Tout, deadcnt, autocounter, hist, accept_count, prescale_r and pass_prescale, and sets the FSM to IDLE.
REQ-046 During reset=1: coax_out, trig_out, ext_trig_out, dead, hist_out and accept_count all read 0.
REQ-047 The first sample of coax_in is taken on the first edge with reset=0.
REQ-048 Reset asserted mid-pulse or mid-DEAD aborts it at the next edge.

Verification
REQ-049 Setup: NCH=16, mask=0x0003, majority=2, coincidence_time=4, prescale=FFFFFFFF, dead_time=10. coax_in[0] and coax_in[1] low 1 cycle, 2 cycles apart -> coax_out[1:0] high 16 cycles, starting 3 cycles after the second hit is sampled; trig_out 1 pulse; accept_count=1.
REQ-050 Same setup with hits 5 cycles apart -> no group output; accept_count=0; hist[0]=hist[1]=1.
REQ-051 Coincidence repeated every 3 cycles with dead_time=10 -> accepted triggers are separated by at least 11 cycles; dead is high for 10 cycles after each trigger.
REQ-052 prescale=0 with randnum=5 -> group coincidence gives no coax_out and no trig_out, but dead still asserts; a hit on channel 7 (unmasked) passes through and coax_out[7] is high 16 cycles.
REQ-053 dorolling=1, rolling_log2=4 -> ext_trig_out high for 4 cycles every 17 cycles; with dorolling=0, ext_trig_out stays 0.
REQ-054 hist[3] preset to 2^HW-1 and one more hit -> value holds (saturates); resethist asserted together with a hit -> hist=0; hist_sel=20 -> hist_out=0.
